rysy_mem_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency, non-pipelined data memory between two bus masters:
//  m0 = rysy_core load/store port, m1 = program loader / debug port.

---
 rtl/rysy_pkg.sv | 21 ++
 rtl/rysy_rr_arb2.sv | 31 +++
 rtl/rysy_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_rysy_mem_arbiter.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rysy_pkg.sv
// ---------------------------------------------------------------------------
// rysy_pkg
// Shared types and constants for the rysy memory-side blocks.
//   arb_state_t : arbiter sequencing state (idle / access in flight)
//   MST_CORE    : master index of the rysy_core load/store port
//   MST_LOAD    : master index of the program loader / debug port
//   CNT_W       : width of the memory latency counter (latency 1..4)
// ---------------------------------------------------------------------------
package rysy_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int MST_CORE = 0;
  localparam int MST_LOAD = 1;

  localparam int CNT_W = 2;

endpackage

// File: rtl/rysy_rr_arb2.sv
// ---------------------------------------------------------------------------
// rysy_rr_arb2
// Purely combinational 2-way arbiter, usable by any shared resource with two
// requesters. Round-robin between simultaneous requests, or fixed priority
// to requester 0 when fixed_prio is set.
// Ports:
//   req        in  [1:0]  request vector (bit N = requester N)
//   last       in  1      index of the requester granted most recently
//   fixed_prio in  1      1 = requester 0 always wins a tie
//   gnt_onehot out [1:0]  one-hot grant, 0 when nothing requests
// ---------------------------------------------------------------------------
module rysy_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed_prio,
  output logic [1:0] gnt_onehot
);

  // On a tie the requester that did not win last time is served, so
  // last=1 hands the tie to requester 0.
  always_comb begin
    gnt_onehot = 2'b00;
    case (req)
      2'b01:   gnt_onehot = 2'b01;
      2'b10:   gnt_onehot = 2'b10;
      2'b11:   gnt_onehot = (fixed_prio || last) ? 2'b01 : 2'b10;
      default: gnt_onehot = 2'b00;
    endcase
  end

endmodule

// File: rtl/rysy_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rysy_mem_arbiter
// Shares one single-port, fixed-latency, non-pipelined data memory between
// m0 (rysy_core load/store port) and m1 (program loader / debug port).
// Grants one access at a time, counts the memory latency and returns the
// completion (and read data) to the master that owns the access.
// Parameters: AW address width, DW data width, MEM_LAT read latency (1..4),
//             FIXED_PRIO (0 = round-robin, 1 = m0 wins ties).
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   mN_req/we/be/addr/wdata  request and payload from master N (held to gnt)
//   mN_gnt                   1-cycle pulse, request accepted
//   mN_rvalid, mN_rdata      1-cycle completion pulse, read data (0 on writes)
//   mem_en/we/be/addr/wdata  memory access strobe and payload
//   mem_rdata                memory read data, valid MEM_LAT cycles after mem_en
// ---------------------------------------------------------------------------
module rysy_mem_arbiter
  import rysy_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_be,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_be,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(MEM_LAT - 1);
  localparam logic             FIXED_BIT = (FIXED_PRIO != 0);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_owner;
  logic             r_owner_we;
  logic             r_last;

  logic             w_slot;
  logic             w_done;
  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  logic             w_win;

  // An issue slot is open when idle or in the completion cycle of the
  // current access. Reset closes it so no grant leaks out while rst is low.
  assign w_slot = rst && ((r_state == ARB_IDLE) || (r_cnt == '0));
  assign w_done = rst && (r_state == ARB_BUSY) && (r_cnt == '0);
  assign w_req  = w_slot ? {m1_req, m0_req} : 2'b00;
  assign w_win  = w_gnt[MST_LOAD];

  rysy_rr_arb2 u_arb (
    .req        (w_req),
    .last       (r_last),
    .fixed_prio (FIXED_BIT),
    .gnt_onehot (w_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A grant in the completion cycle keeps the arbiter busy, which is what
  // gives back-to-back accesses with no idle cycle on mem_en.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (|w_gnt) w_state_nxt = ARB_BUSY;
      ARB_BUSY: if (r_cnt == '0) w_state_nxt = (|w_gnt) ? ARB_BUSY : ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  // Owner bookkeeping and latency countdown. last only moves on a real grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_owner    <= 1'b0;
      r_owner_we <= 1'b0;
      r_last     <= 1'b1;
    end else if (|w_gnt) begin
      r_cnt      <= CNT_INIT;
      r_owner    <= w_win;
      r_owner_we <= w_win ? m1_we : m0_we;
      r_last     <= w_win;
    end else if ((r_state == ARB_BUSY) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Request mux towards the memory and response demux back to the owner.
  // Payload outputs are forced to zero whenever no access is issued.
  always_comb begin
    m0_gnt    = w_gnt[MST_CORE];
    m1_gnt    = w_gnt[MST_LOAD];
    mem_en    = |w_gnt;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt[MST_CORE]) begin
      mem_we    = m0_we;
      mem_be    = m0_be;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (w_gnt[MST_LOAD]) begin
      mem_we    = m1_we;
      mem_be    = m1_be;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
    m0_rvalid = w_done && !r_owner;
    m1_rvalid = w_done && r_owner;
    m0_rdata  = '0;
    m1_rdata  = '0;
    if (w_done && !r_owner_we) begin
      if (r_owner) begin
        m1_rdata = mem_rdata;
      end else begin
        m0_rdata = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_rysy_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rysy_mem_arbiter
// Three arbiter instances share one clock:
//   inst 0 : MEM_LAT=1, round-robin
//   inst 1 : MEM_LAT=2, round-robin
//   inst 2 : MEM_LAT=3, fixed priority
// Each instance has its own latency-accurate memory stub that returns a
// fixed function of the address. Directed scenarios are followed by
// randomized traffic checked against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_rysy_mem_arbiter;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst_n     [NI];
  logic        m0_req    [NI];
  logic        m0_we     [NI];
  logic [3:0]  m0_be     [NI];
  logic [31:0] m0_addr   [NI];
  logic [31:0] m0_wdata  [NI];
  logic        m0_gnt    [NI];
  logic        m0_rvalid [NI];
  logic [31:0] m0_rdata  [NI];
  logic        m1_req    [NI];
  logic        m1_we     [NI];
  logic [3:0]  m1_be     [NI];
  logic [31:0] m1_addr   [NI];
  logic [31:0] m1_wdata  [NI];
  logic        m1_gnt    [NI];
  logic        m1_rvalid [NI];
  logic [31:0] m1_rdata  [NI];
  logic        mem_en    [NI];
  logic        mem_we    [NI];
  logic [3:0]  mem_be    [NI];
  logic [31:0] mem_addr  [NI];
  logic [31:0] mem_wdata [NI];
  logic [31:0] mem_rdata [NI];
  logic [31:0] memCap    [NI];
  logic [31:0] memPipe   [NI][4];

  // Memory contents: 0x10 holds 0xDEADBEEF, everything else is a hash.
  function automatic logic [31:0] memFn(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  generate
    for (genvar g = 0; g < NI; g++) begin : gDut
      rysy_mem_arbiter #(
        .AW(32), .DW(32), .MEM_LAT(g + 1), .FIXED_PRIO(g == 2 ? 1 : 0)
      ) dut (
        .clk(clk), .rst(rst_n[g]),
        .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_be(m0_be[g]),
        .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
        .m0_gnt(m0_gnt[g]), .m0_rvalid(m0_rvalid[g]), .m0_rdata(m0_rdata[g]),
        .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_be(m1_be[g]),
        .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
        .m1_gnt(m1_gnt[g]), .m1_rvalid(m1_rvalid[g]), .m1_rdata(m1_rdata[g]),
        .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]),
        .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
        .mem_rdata(mem_rdata[g])
      );
      // Latency g+1: the value captured in the issue cycle reaches stage g.
      assign mem_rdata[g] = memPipe[g][g];
    end
  endgenerate

  // Memory stub: capture the addressed word mid-cycle, shift it on each edge.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) memCap[k] <= mem_en[k] ? memFn(mem_addr[k]) : 32'h0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      memPipe[k][0] <= memCap[k];
      for (int i = 1; i < 4; i++) memPipe[k][i] <= memPipe[k][i-1];
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired got=running want=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs(input int k);
    m0_req[k] = 1'b0; m0_we[k] = 1'b0; m0_be[k] = 4'h0; m0_addr[k] = 32'h0; m0_wdata[k] = 32'h0;
    m1_req[k] = 1'b0; m1_we[k] = 1'b0; m1_be[k] = 4'h0; m1_addr[k] = 32'h0; m1_wdata[k] = 32'h0;
  endtask

  task automatic resetInst(input int k);
    clearInputs(k);
    rst_n[k] = 1'b0;
    tick();
    tick();
    rst_n[k] = 1'b1;
  endtask

  task automatic newPayload(input int k, input int m);
    logic [31:0] a;
    a = $urandom & 32'h0000_FFFC;
    if (m == 0) begin
      m0_req[k] = 1'b1; m0_we[k] = 1'($urandom_range(1)); m0_be[k] = 4'($urandom);
      m0_addr[k] = a; m0_wdata[k] = $urandom;
    end else begin
      m1_req[k] = 1'b1; m1_we[k] = 1'($urandom_range(1)); m1_be[k] = 4'($urandom);
      m1_addr[k] = a; m1_wdata[k] = $urandom;
    end
  endtask

  // Outputs must be quiet under reset even with a request pending.
  task automatic test_reset;
    logic [5:0]   ctrl;
    logic [107:0] dat;
    for (int k = 0; k < NI; k++) begin
      clearInputs(k);
      rst_n[k] = 1'b1;
    end
    #2;
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b0;
    m0_req[0] = 1'b1; m0_addr[0] = 32'h44; m0_be[0] = 4'hF;
    m1_req[1] = 1'b1; m1_addr[1] = 32'h48; m1_we[1] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      ctrl = {m0_gnt[k], m1_gnt[k], m0_rvalid[k], m1_rvalid[k], mem_en[k], mem_we[k]};
      checks++;
      if (ctrl !== 6'b0) begin
        failures++;
        $display("[TB] FAIL reset_ctrl inst=%0d got=%b want=000000", k, ctrl);
      end
      dat = {mem_be[k], mem_addr[k], mem_wdata[k], m0_rdata[k] | m1_rdata[k]};
      checks++;
      if (dat !== 108'h0) begin
        failures++;
        $display("[TB] FAIL reset_data inst=%0d got=%h want=0", k, dat);
      end
    end
    clearInputs(0);
    clearInputs(1);
    tick();
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      ctrl = {m0_gnt[k], m1_gnt[k], m0_rvalid[k], m1_rvalid[k], mem_en[k], mem_we[k]};
      checks++;
      if (ctrl !== 6'b0) begin
        failures++;
        $display("[TB] FAIL idle_no_req inst=%0d got=%b want=000000", k, ctrl);
      end
    end
  endtask

  // MEM_LAT=1 read of 0x10: grant and strobe now, data one cycle later.
  task automatic test_single_read;
    tick();
    m0_req[0] = 1'b1; m0_we[0] = 1'b0; m0_be[0] = 4'hF; m0_addr[0] = 32'h10;
    @(negedge clk);
    checks++;
    if ({m0_gnt[0], m1_gnt[0], mem_en[0], mem_we[0]} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL read_issue got=%b want=1010", {m0_gnt[0], m1_gnt[0], mem_en[0], mem_we[0]});
    end
    checks++;
    if (mem_addr[0] !== 32'h10) begin
      failures++;
      $display("[TB] FAIL read_addr got=%h want=00000010", mem_addr[0]);
    end
    tick();
    m0_req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({m0_rvalid[0], m1_rvalid[0], mem_en[0]} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL read_rvalid got=%b want=100", {m0_rvalid[0], m1_rvalid[0], mem_en[0]});
    end
    checks++;
    if (m0_rdata[0] !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL read_data got=%h want=deadbeef", m0_rdata[0]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (m0_rvalid[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL read_single_pulse got=%b want=0", m0_rvalid[0]);
    end
  endtask

  // m1 write on the MEM_LAT=2 instance: completion carries rdata=0.
  task automatic test_write;
    tick();
    m1_req[1] = 1'b1; m1_we[1] = 1'b1; m1_be[1] = 4'b0011;
    m1_addr[1] = 32'h20; m1_wdata[1] = 32'h1234ABCD;
    @(negedge clk);
    checks++;
    if ({m1_gnt[1], m0_gnt[1], mem_en[1], mem_we[1]} !== 4'b1011) begin
      failures++;
      $display("[TB] FAIL write_issue got=%b want=1011", {m1_gnt[1], m0_gnt[1], mem_en[1], mem_we[1]});
    end
    checks++;
    if ({mem_be[1], mem_addr[1], mem_wdata[1]} !== {4'b0011, 32'h20, 32'h1234ABCD}) begin
      failures++;
      $display("[TB] FAIL write_payload got=%h want=%h", {mem_be[1], mem_addr[1], mem_wdata[1]},
               {4'b0011, 32'h20, 32'h1234ABCD});
    end
    tick();
    m1_req[1] = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_rvalid[1], mem_en[1]} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL write_wait got=%b want=00", {m1_rvalid[1], mem_en[1]});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({m1_rvalid[1], m0_rvalid[1], m1_rdata[1]} !== {2'b10, 32'h0}) begin
      failures++;
      $display("[TB] FAIL write_done got=%h want=%h", {m1_rvalid[1], m0_rvalid[1], m1_rdata[1]}, {2'b10, 32'h0});
    end
  endtask

  // Both masters request from reset, two accesses each, round-robin, MEM_LAT=2.
  task automatic test_rr_order;
    int order[$];
    int gcyc[$];
    int n0, n1;
    bit both, g0, g1;
    n0 = 0; n1 = 0; both = 1'b0;
    resetInst(1);
    tick();
    m0_req[1] = 1'b1; m0_we[1] = 1'b0; m0_be[1] = 4'hF; m0_addr[1] = 32'h100;
    m1_req[1] = 1'b1; m1_we[1] = 1'b0; m1_be[1] = 4'hF; m1_addr[1] = 32'h200;
    for (int cyc = 0; cyc < 40 && (n0 < 2 || n1 < 2); cyc++) begin
      @(negedge clk);
      g0 = m0_gnt[1];
      g1 = m1_gnt[1];
      if (g0 && g1) both = 1'b1;
      if (g0) begin order.push_back(0); gcyc.push_back(cyc); n0++; end
      if (g1) begin order.push_back(1); gcyc.push_back(cyc); n1++; end
      tick();
      if (g0) begin
        if (n0 < 2) m0_addr[1] = m0_addr[1] + 32'h4;
        else m0_req[1] = 1'b0;
      end
      if (g1) begin
        if (n1 < 2) m1_addr[1] = m1_addr[1] + 32'h4;
        else m1_req[1] = 1'b0;
      end
    end
    clearInputs(1);
    checks++;
    if (both) begin
      failures++;
      $display("[TB] FAIL rr_both_gnt got=1 want=0");
    end
    checks++;
    if (order.size() != 4) begin
      failures++;
      $display("[TB] FAIL rr_grant_count got=%0d want=4", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      checks++;
      if (order[i] != (i % 2)) begin
        failures++;
        $display("[TB] FAIL rr_order idx=%0d got=m%0d want=m%0d", i, order[i], i % 2);
      end
    end
    for (int i = 1; i < gcyc.size(); i++) begin
      checks++;
      if (gcyc[i] - gcyc[i-1] != 2) begin
        failures++;
        $display("[TB] FAIL rr_spacing idx=%0d got=%0d want=2", i, gcyc[i] - gcyc[i-1]);
      end
    end
    repeat (3) tick();
  endtask

  // Fixed priority, MEM_LAT=3: m0 takes every slot until it drops its request.
  task automatic test_fixed_prio;
    int nG0, nG1, badSp;
    bit g0;
    nG0 = 0; nG1 = 0; badSp = 0;
    resetInst(2);
    tick();
    m0_req[2] = 1'b1; m0_we[2] = 1'b0; m0_be[2] = 4'hF; m0_addr[2] = 32'h300;
    m1_req[2] = 1'b1; m1_we[2] = 1'b0; m1_be[2] = 4'hF; m1_addr[2] = 32'h400;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      g0 = m0_gnt[2];
      if (m1_gnt[2]) nG1++;
      if (g0) begin
        nG0++;
        if (cyc % 3 != 0) badSp++;
      end
      tick();
      if (g0) m0_addr[2] = m0_addr[2] + 32'h4;
    end
    m0_req[2] = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_gnt[2], m0_gnt[2], m0_rvalid[2]} !== 3'b101) begin
      failures++;
      $display("[TB] FAIL fp_handover got=%b want=101", {m1_gnt[2], m0_gnt[2], m0_rvalid[2]});
    end
    checks++;
    if (nG1 != 0) begin
      failures++;
      $display("[TB] FAIL fp_m1_starved got=%0d want=0", nG1);
    end
    checks++;
    if (nG0 != 4) begin
      failures++;
      $display("[TB] FAIL fp_m0_grants got=%0d want=4", nG0);
    end
    checks++;
    if (badSp != 0) begin
      failures++;
      $display("[TB] FAIL fp_spacing got=%0d want=0", badSp);
    end
    tick();
    clearInputs(2);
    repeat (4) tick();
  endtask

  // MEM_LAT=1: m0 keeps requesting with a new address in every rvalid cycle.
  task automatic test_back_to_back;
    logic [31:0] a;
    tick();
    m0_req[0] = 1'b1; m0_we[0] = 1'b0; m0_be[0] = 4'hF; m0_addr[0] = 32'h40;
    for (int i = 0; i < 6; i++) begin
      a = 32'h40 + 32'(4 * i);
      @(negedge clk);
      checks++;
      if ({m0_gnt[0], mem_en[0], mem_addr[0]} !== {2'b11, a}) begin
        failures++;
        $display("[TB] FAIL b2b_issue idx=%0d got=%h want=%h", i, {m0_gnt[0], mem_en[0], mem_addr[0]}, {2'b11, a});
      end
      if (i > 0) begin
        checks++;
        if ({m0_rvalid[0], m0_rdata[0]} !== {1'b1, memFn(a - 32'h4)}) begin
          failures++;
          $display("[TB] FAIL b2b_resp idx=%0d got=%h want=%h", i, {m0_rvalid[0], m0_rdata[0]},
                   {1'b1, memFn(a - 32'h4)});
        end
      end
      tick();
      m0_addr[0] = a + 32'h4;
    end
    m0_req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({m0_rvalid[0], mem_en[0], m0_rdata[0]} !== {2'b10, memFn(32'h54)}) begin
      failures++;
      $display("[TB] FAIL b2b_last got=%h want=%h", {m0_rvalid[0], mem_en[0], m0_rdata[0]}, {2'b10, memFn(32'h54)});
    end
    clearInputs(0);
  endtask

  // MEM_LAT=3: reset one cycle after a grant drops the access silently.
  task automatic test_reset_midflight;
    int badRv;
    badRv = 0;
    resetInst(2);
    tick();
    m0_req[2] = 1'b1; m0_we[2] = 1'b0; m0_be[2] = 4'hF; m0_addr[2] = 32'h80;
    @(negedge clk);
    checks++;
    if (m0_gnt[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rm_grant got=%b want=1", m0_gnt[2]);
    end
    tick();
    m0_req[2] = 1'b0;
    m1_req[2] = 1'b1; m1_we[2] = 1'b0; m1_be[2] = 4'hF; m1_addr[2] = 32'h90;
    #1 rst_n[2] = 1'b0;
    #1;
    checks++;
    if ({m0_gnt[2], m1_gnt[2], m0_rvalid[2], m1_rvalid[2], mem_en[2], mem_addr[2]} !== 37'h0) begin
      failures++;
      $display("[TB] FAIL rm_in_reset got=%h want=0",
               {m0_gnt[2], m1_gnt[2], m0_rvalid[2], m1_rvalid[2], mem_en[2], mem_addr[2]});
    end
    tick();
    m1_req[2] = 1'b0;
    rst_n[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m0_rvalid[2] || m1_rvalid[2]) badRv++;
    end
    checks++;
    if (badRv != 0) begin
      failures++;
      $display("[TB] FAIL rm_no_rvalid got=%0d want=0", badRv);
    end
    tick();
    m1_req[2] = 1'b1; m1_we[2] = 1'b0; m1_be[2] = 4'hF; m1_addr[2] = 32'h30;
    @(negedge clk);
    checks++;
    if ({m1_gnt[2], mem_addr[2]} !== {1'b1, 32'h30}) begin
      failures++;
      $display("[TB] FAIL rm_regrant got=%h want=%h", {m1_gnt[2], mem_addr[2]}, {1'b1, 32'h30});
    end
    for (int j = 1; j <= 3; j++) begin
      tick();
      m1_req[2] = 1'b0;
      @(negedge clk);
      checks++;
      if (j < 3) begin
        if (m1_rvalid[2] !== 1'b0) begin
          failures++;
          $display("[TB] FAIL rm_early_rvalid cyc=%0d got=%b want=0", j, m1_rvalid[2]);
        end
      end else if ({m1_rvalid[2], m1_rdata[2]} !== {1'b1, memFn(32'h30)}) begin
        failures++;
        $display("[TB] FAIL rm_resp got=%h want=%h", {m1_rvalid[2], m1_rdata[2]}, {1'b1, memFn(32'h30)});
      end
    end
    clearInputs(2);
  endtask

  // Random traffic against a transaction-level model: an access granted at
  // cycle g completes at g+L, and the next grant may happen no earlier than
  // that completion cycle.
  task automatic test_random(input int k, input int n);
    int          lat, gcyc, owner, last, win;
    bit          fixedP, busy, oWe, g0, g1;
    logic [31:0] oAddr, expR0, expR1;
    logic [4:0]  expCtrl, gotCtrl;
    logic [68:0] expPay;
    lat = k + 1; fixedP = (k == 2); busy = 1'b0; last = 1;
    gcyc = 0; owner = 0; oWe = 1'b0; oAddr = 32'h0; g0 = 1'b0; g1 = 1'b0;
    resetInst(k);
    for (int cyc = 0; cyc < n; cyc++) begin
      tick();
      if (!m0_req[k] || g0) begin
        if ($urandom_range(99) < 55) newPayload(k, 0); else m0_req[k] = 1'b0;
      end else if ($urandom_range(99) < 3) m0_req[k] = 1'b0;
      if (!m1_req[k] || g1) begin
        if ($urandom_range(99) < 55) newPayload(k, 1); else m1_req[k] = 1'b0;
      end else if ($urandom_range(99) < 3) m1_req[k] = 1'b0;
      @(negedge clk);
      expCtrl = 5'b0; expR0 = 32'h0; expR1 = 32'h0; expPay = 69'h0; win = -1;
      if (busy && cyc == gcyc + lat) begin
        if (owner == 0) begin expCtrl[1] = 1'b1; expR0 = oWe ? 32'h0 : memFn(oAddr); end
        else begin expCtrl[0] = 1'b1; expR1 = oWe ? 32'h0 : memFn(oAddr); end
        busy = 1'b0;
      end
      if (!busy) begin
        if (m0_req[k] && m1_req[k]) win = fixedP ? 0 : (last == 0 ? 1 : 0);
        else if (m0_req[k]) win = 0;
        else if (m1_req[k]) win = 1;
      end
      if (win == 0) begin
        expCtrl[4] = 1'b1; expCtrl[2] = 1'b1;
        expPay = {m0_we[k], m0_be[k], m0_addr[k], m0_wdata[k]};
        oWe = m0_we[k]; oAddr = m0_addr[k];
      end else if (win == 1) begin
        expCtrl[3] = 1'b1; expCtrl[2] = 1'b1;
        expPay = {m1_we[k], m1_be[k], m1_addr[k], m1_wdata[k]};
        oWe = m1_we[k]; oAddr = m1_addr[k];
      end
      if (win >= 0) begin
        busy = 1'b1; gcyc = cyc; owner = win; last = win;
      end
      gotCtrl = {m0_gnt[k], m1_gnt[k], mem_en[k], m0_rvalid[k], m1_rvalid[k]};
      checks++;
      if (gotCtrl !== expCtrl) begin
        failures++;
        $display("[TB] FAIL rnd_ctrl inst=%0d cyc=%0d got=%b want=%b", k, cyc, gotCtrl, expCtrl);
      end
      checks++;
      if ({m0_rdata[k], m1_rdata[k]} !== {expR0, expR1}) begin
        failures++;
        $display("[TB] FAIL rnd_rdata inst=%0d cyc=%0d got=%h want=%h", k, cyc, {m0_rdata[k], m1_rdata[k]},
                 {expR0, expR1});
      end
      if (expCtrl[2]) begin
        checks++;
        if ({mem_we[k], mem_be[k], mem_addr[k], mem_wdata[k]} !== expPay) begin
          failures++;
          $display("[TB] FAIL rnd_payload inst=%0d cyc=%0d got=%h want=%h", k, cyc,
                   {mem_we[k], mem_be[k], mem_addr[k], mem_wdata[k]}, expPay);
        end
      end
      g0 = m0_gnt[k];
      g1 = m1_gnt[k];
    end
    tick();
    clearInputs(k);
    repeat (5) tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_rr_order();
    test_fixed_prio();
    test_back_to_back();
    test_reset_midflight();
    test_random(0, 200);
    test_random(1, 300);
    test_random(2, 300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
